// File: rtl/mask_accum_pkg.sv
// Shared types and width helpers for the masked coefficient accumulator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mask_accum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Result width: enough headroom to add every slot without wrap-around.
    function automatic int calc_max(input int bits, input int cges);
        return $clog2(cges) + bits;
    endfunction

    // Number of accumulate beats needed to visit every slot.
    function automatic int calc_depth(input int cges, input int lanes);
        return (cges + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/csa_lane_tree.sv
// Carry-save reduction of N operands (lane terms plus running vs/vc) to a sum/carry pair.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the outputs.
module csa_lane_tree #(
    parameter int W = 14,
    parameter int N = 9
) (
    input  logic [N-1:0][W-1:0] terms,
    output logic [W-1:0]        vs,
    output logic [W-1:0]        vc
);

    // Stage j holds the redundant pair after folding operands 0..j+1.
    logic [W-1:0] s_st [N-1];
    logic [W-1:0] c_st [N-1];

    assign s_st[0] = terms[0];
    assign c_st[0] = terms[1];

    // Each stage is one 3:2 compressor; carries shift left and wrap modulo 2^W.
    for (genvar i = 2; i < N; i++) begin : g_csa
        assign s_st[i-1] = s_st[i-2] ^ c_st[i-2] ^ terms[i];
        assign c_st[i-1] = ((s_st[i-2] & c_st[i-2]) |
                            (s_st[i-2] & terms[i])  |
                            (c_st[i-2] & terms[i])) << 1;
    end

    assign vs = s_st[N-2];
    assign vc = c_st[N-2];

endmodule

// File: rtl/mask_accum_engine.sv
// Sums the coefficients selected by a mask, LANES slots per beat, in carry-save form.
// Latency: result valid DEPTH+2 cycles after start is accepted (DEPTH beats, resolve, done).
// Backpressure: result held in DONE until res_ready; new starts ignored while busy.
// Build option: define MASK_ACCUM_SIGNED_EN for two's complement coefficients and result.
module mask_accum_engine
    import mask_accum_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int CGES  = 49,
    parameter int LANES = 7,
    localparam int MAX   = calc_max(BITS, CGES),
    localparam int DEPTH = calc_depth(CGES, LANES),
    localparam int AW    = $clog2(CGES)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            coeff_wen,
    input  logic [AW-1:0]   coeff_addr,
    input  logic [BITS-1:0] coeff_data,
    input  logic            start,
    input  logic [CGES-1:0] cges,
    input  logic            abort,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [MAX-1:0]  result
);

    localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [BW-1:0] beat_t;
    typedef logic [AW-1:0] addr_t;

    state_t              state;
    state_t              state_nxt;
    beat_t               beat;
    logic [CGES-1:0]     mask;
    logic [MAX-1:0]      vs;
    logic [MAX-1:0]      vc;
    logic [MAX-1:0]      tree_vs;
    logic [MAX-1:0]      tree_vc;
    logic [BITS-1:0]     coeff     [CGES];
    logic [MAX-1:0]      slot_term [CGES];
    logic [LANES+1:0][MAX-1:0] terms;

    // Widen a coefficient to result width, sign- or zero-extending by build.
    function automatic logic [MAX-1:0] extend(input logic [BITS-1:0] c);
`ifdef MASK_ACCUM_SIGNED_EN
        return {{(MAX-BITS){c[BITS-1]}}, c};
`else
        return {{(MAX-BITS){1'b0}}, c};
`endif
    endfunction

    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    for (genvar g = 0; g < CGES; g++) begin : g_slot
        // Coefficient slot g: writable only while idle, cleared by reset.
        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                coeff[g] <= '0;
            end else if (coeff_wen && (state == IDLE) && (coeff_addr == addr_t'(g))) begin
                coeff[g] <= coeff_data;
            end
        end

        assign slot_term[g] = mask[g] ? extend(coeff[g]) : '0;
    end

    // Lane l on beat k carries slot k*LANES+l; slots past CGES read as zero.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [MAX-1:0] by_beat [DEPTH];
        for (genvar k = 0; k < DEPTH; k++) begin : g_beat
            if (k * LANES + l < CGES) begin : g_in
                assign by_beat[k] = slot_term[k * LANES + l];
            end else begin : g_pad
                assign by_beat[k] = '0;
            end
        end
        assign terms[l] = by_beat[beat];
    end

    assign terms[LANES]   = vs;
    assign terms[LANES+1] = vc;

    csa_lane_tree #(
        .W (MAX),
        .N (LANES + 2)
    ) u_tree (
        .terms (terms),
        .vs    (tree_vs),
        .vc    (tree_vc)
    );

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: abort only cancels work in flight; start beats abort in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (beat == beat_t'(DEPTH - 1)) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture mask on start, fold one beat per ACCUM cycle, resolve once.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mask   <= '0;
            vs     <= '0;
            vc     <= '0;
            beat   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask <= cges;
                        vs   <= '0;
                        vc   <= '0;
                        beat <= '0;
                    end
                end
                ACCUM: begin
                    if (!abort) begin
                        vs   <= tree_vs;
                        vc   <= tree_vc;
                        beat <= beat + 1'b1;
                    end
                end
                RESOLVE: begin
                    if (!abort) begin
                        result <= vs + vc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_accum_engine.sv
module tb_mask_accum_engine;

    localparam int BITS  = 8;
    localparam int CGES  = 49;
    localparam int LANES = 7;
    localparam int MAX   = 14;
    localparam int AW    = 6;
    localparam int LAT   = 9;

    logic            CLK = 1'b0;
    logic            reset;
    logic            coeff_wen;
    logic [AW-1:0]   coeff_addr;
    logic [BITS-1:0] coeff_data;
    logic            start;
    logic [CGES-1:0] cges;
    logic            abort;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [MAX-1:0]  result;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] model_coeff [CGES];
    logic [CGES-1:0] all_ones;

    mask_accum_engine #(
        .BITS  (BITS),
        .CGES  (CGES),
        .LANES (LANES)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .coeff_wen  (coeff_wen),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .start      (start),
        .cges       (cges),
        .abort      (abort),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain sum of the selected coefficient values, wrapped to MAX bits.
    function automatic logic [MAX-1:0] model_result(input logic [CGES-1:0] m);
        longint sum;
        sum = 0;
        for (int i = 0; i < CGES; i++) begin
            if (m[i]) begin
`ifdef MASK_ACCUM_SIGNED_EN
                sum += longint'($signed(model_coeff[i]));
`else
                sum += longint'(model_coeff[i]);
`endif
            end
        end
        return sum[MAX-1:0];
    endfunction

    task automatic write_coeff(input int addr, input logic [BITS-1:0] data);
        @(negedge CLK);
        coeff_wen  = 1'b1;
        coeff_addr = addr[AW-1:0];
        coeff_data = data;
        @(negedge CLK);
        coeff_wen  = 1'b0;
        if (addr < CGES) model_coeff[addr] = data;
    endtask

    task automatic run_op(input string tag, input logic [CGES-1:0] m);
        int             lat;
        logic [MAX-1:0] exp;
        logic [63:0]    scramble;
        exp = model_result(m);
        @(negedge CLK);
        start = 1'b1;
        cges  = m;
        @(negedge CLK);
        start    = 1'b0;
        scramble = {$urandom(), $urandom()};
        cges     = scramble[CGES-1:0];
        lat      = 1;
        check({tag, "_busy"}, busy, 1);
        while (!res_valid && lat < 30) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_result"}, result, exp);
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        check({tag, "_idle_after"}, {busy, res_valid}, 2'b00);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (res_valid || busy) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [63:0]    rnd;
        logic [MAX-1:0] held;
        int             lat;

        all_ones   = '1;
        reset      = 1'b1;
        coeff_wen  = 1'b0;
        coeff_addr = '0;
        coeff_data = '0;
        start      = 1'b0;
        cges       = '0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        for (int i = 0; i < CGES; i++) model_coeff[i] = '0;

        repeat (3) @(negedge CLK);
        check("reset_busy", busy, 0);
        check("reset_valid", res_valid, 0);
        check("reset_result", result, 0);
        reset = 1'b0;

        // Ramp coefficients: full mask, top slot only, empty mask.
        for (int i = 0; i < CGES; i++) write_coeff(i, BITS'(i + 1));
        run_op("ramp_all", all_ones);
        check("ramp_all_const", result, 1225);
        run_op("ramp_bit48", CGES'(1) << 48);
        check("ramp_bit48_const", result, 49);
        run_op("ramp_zero", '0);
        check("ramp_zero_const", result, 0);

        // Abort on beat 3, with a write to slot 0 attempted mid-accumulation.
        @(negedge CLK);
        start = 1'b1;
        cges  = all_ones;
        @(negedge CLK);
        start      = 1'b0;
        coeff_wen  = 1'b1;
        coeff_addr = '0;
        coeff_data = 8'h77;
        @(negedge CLK);
        coeff_wen = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy_drop", busy, 0);
        expect_quiet("abort_no_valid", 15);
        run_op("after_abort", all_ones);
        check("after_abort_const", result, 1225);

        // Hold the result under backpressure and try to start again in DONE.
        @(negedge CLK);
        start = 1'b1;
        cges  = all_ones;
        @(negedge CLK);
        start = 1'b0;
        lat   = 1;
        while (!res_valid && lat < 30) begin
            @(negedge CLK);
            lat++;
        end
        check("hold_latency", lat, LAT);
        held = result;
        check("hold_first", held, model_result(all_ones));
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            cges  = '0;
            @(negedge CLK);
            check("hold_stable", {res_valid, result}, {1'b1, held});
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        expect_quiet("hold_start_ignored", 12);

        // Reset in the middle of ACCUM clears everything at once.
        @(negedge CLK);
        start = 1'b1;
        cges  = all_ones;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {busy, res_valid, result}, '0);
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < CGES; i++) model_coeff[i] = '0;
        expect_quiet("midreset_no_valid", 12);
        run_op("midreset_cleared", all_ones);
        check("midreset_cleared_const", result, 0);

        // Largest coefficient everywhere.
        for (int i = 0; i < CGES; i++) write_coeff(i, 8'hFF);
        run_op("max_all", all_ones);
`ifdef MASK_ACCUM_SIGNED_EN
        check("max_all_const", result, 16335);
`else
        check("max_all_const", result, 12495);
`endif

        // A negative-looking coefficient paired with a small positive one.
        write_coeff(0, 8'hFD);
        write_coeff(1, 8'h02);
        run_op("pair", CGES'(3));
`ifdef MASK_ACCUM_SIGNED_EN
        check("pair_const", result, 14'h3FFF);
`else
        check("pair_const", result, 255);
`endif

        // Random coefficient updates (some to unmapped slots) and random masks.
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 6; w++) begin
                write_coeff(int'($urandom_range(0, 63)), BITS'($urandom()));
            end
            rnd = {$urandom(), $urandom()};
            run_op("rand", rnd[CGES-1:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_accum_engine.md
MASK_ACCUM_ENGINE -- requirements
Module: mask_accum_engine

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning coefficient width.
REQ-002 SHALL have parameter CGES, default 49, meaning number of coefficient slots and mask bits.
REQ-003 SHALL have parameter LANES, default 7, meaning terms reduced per cycle (1..CGES).
REQ-004 SHALL define localparam MAX = $clog2(CGES)+BITS as result width, and DEPTH = ceil(CGES/LANES) as accumulate beats.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
  CLK  input  1  clock, rising edge.
  reset  input  1  asynchronous active-high reset.
  coeff_wen  input  1  coefficient write strobe.
  coeff_addr  input  $clog2(CGES)  coefficient slot index.
  coeff_data  input  BITS  coefficient value.
  start  input  1  begin one accumulation.
  cges  input  CGES  selection mask, sampled on accepted start.
  abort  input  1  cancel running accumulation.
  busy  output  1  high outside IDLE.
  res_valid  output  1  result available.
  res_ready  input  1  consumer accepts result.
  result  output  MAX  sum of selected coefficients.

Function
REQ-006 SHALL hold CGES coefficient registers; write when coeff_wen=1, state IDLE, coeff_addr<CGES; otherwise the write is dropped.
REQ-007 SHALL implement FSM IDLE->ACCUM->RESOLVE->DONE->IDLE.
REQ-008 IDLE: start=1 SHALL latch cges into a mask register, clear vs/vc, go ACCUM; start outside IDLE SHALL be ignored.
REQ-009 ACCUM: beat k (0..DEPTH-1) SHALL add coeff[i] for i in [k*LANES, k*LANES+LANES-1], i<CGES, mask bit set, into carry-save pair vs/vc via 3:2 compressor tree; unselected/out-of-range lanes contribute 0.
REQ-010 ACCUM SHALL last exactly DEPTH cycles, then RESOLVE.
REQ-011 RESOLVE SHALL compute vs+vc (MAX bits, modulo 2^MAX) into result register in one cycle, then DONE.
REQ-012 DONE: res_valid=1, result stable until res_valid&&res_ready; then IDLE next cycle.
REQ-013 Latency start-accepted to res_valid SHALL be DEPTH+2 cycles.
REQ-014 abort=1 in ACCUM or RESOLVE SHALL go IDLE next cycle, no res_valid; abort in DONE or IDLE SHALL be ignored.
REQ-015 start and abort both high in IDLE: start wins.
REQ-016 All-zero mask SHALL yield result 0 after normal latency.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 reset=1 SHALL asynchronously force state IDLE, busy=0, res_valid=0, result=0, vs=vc=0, mask=0, all coefficients 0.
REQ-019 reset asserted mid-operation SHALL discard the operation; no res_valid after release until a new start.

Configuration
REQ-020 With MASK_ACCUM_SIGNED_EN defined, coefficients SHALL be two's complement, sign-extended to MAX before compression, result signed.
REQ-021 Without MASK_ACCUM_SIGNED_EN, coefficients SHALL be unsigned, zero-extended.

Structure
REQ-022 Shared package mask_accum_pkg SHALL hold the FSM state enum (IDLE, ACCUM, RESOLVE, DONE) and MAX/DEPTH width helper functions.
REQ-023 Compressor tree SHALL be sub-module csa_lane_tree (LANES+2 inputs -> vs/vc, combinational); FSM, storage, CPA in top.

Verification
REQ-024 BITS=8, CGES=49, LANES=7; coeff[i]=i+1; mask all ones; start -> res_valid at cycle 9, result=1225.
REQ-025 Same coeffs, mask bit 48 only -> result=49; mask 0 -> result=0, latency 9.
REQ-026 All coeff=255, mask all ones -> result=12495, no overflow in MAX=14 bits.
REQ-027 abort at ACCUM beat 3 -> busy drops next cycle, res_valid never asserts; write attempt during ACCUM to slot 0 has no effect on next result.
REQ-028 Hold res_ready=0 for 5 cycles in DONE -> result stable, second start ignored; reset pulse mid-ACCUM -> all outputs 0 immediately.
REQ-029 MASK_ACCUM_SIGNED_EN defined, coeff[0]=-3 (0xFD), coeff[1]=2, mask=0b11 -> result=-1 (all ones, 14 bits).
